rca_acc_seq: RTL and testbench

- Sequential operand front-end and result stage for the 3-bit ripple-carry adder (rca).
- Accepts a valid/ready stream of 3-bit operands and drives the adder's a/b/cin from registers.
- Captures sum/cout into registers and presents them on a valid/ready output.
- Two modes: pair add (two beats, A then B) or accumulate (running sum over a beat stream ending at in_last, with overflow counting).

---
 rtl/rca_acc_seq.sv | 190 +++++++++++++++++++
 tb/tb_rca_acc_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_acc_seq.sv
// ---------------------------------------------------------------------------
// rca_acc_seq
//
// Sequential operand front-end and result stage for a W-bit ripple-carry
// adder that lives outside this block. Operands arrive as a valid/ready
// beat stream. The adder inputs are driven from registers, and its sum and
// carry are captured into result registers. Those registers are presented
// on a valid/ready result port.
//
// Modes (sampled on the first beat of a transaction):
//   pair       (mode=0): two beats, A then B. in_cin is taken with B.
//   accumulate (mode=1): running sum over beats ending at in_last. The
//                        carry out is sticky, and carries are counted in a
//                        saturating counter.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   in_data, in_cin       operand and pair-mode carry-in
//   in_last               final beat of an accumulate stream
//   mode                  0 = pair, 1 = accumulate
//   rca_a/b/cin           drive to the external adder
//   rca_sum/cout          result from the external adder
//   out_valid / out_ready result handshake
//   out_sum, out_cout     registered result and carry (sticky in accumulate)
//   out_ovf_cnt           accumulate-mode count of carry-producing adds
// ---------------------------------------------------------------------------
module rca_acc_seq #(
    parameter int W     = 3,
    parameter int OVF_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_cin,
    input  logic             in_last,
    input  logic             mode,
    output logic [W-1:0]     rca_a,
    output logic [W-1:0]     rca_b,
    output logic             rca_cin,
    input  logic [W-1:0]     rca_sum,
    input  logic             rca_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_cout,
    output logic [OVF_W-1:0] out_ovf_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        ADD    = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

    state_t           state_q, state_d;
    logic [W-1:0]     op_a_q,  op_a_d;
    logic [W-1:0]     op_b_q,  op_b_d;
    logic             cin_q,   cin_d;
    logic             mode_q,  mode_d;
    logic             last_q,  last_d;
    logic [W-1:0]     res_q,   res_d;
    logic             cout_q,  cout_d;
    logic [OVF_W-1:0] ovf_q,   ovf_d;

    logic accept;

    // Beats are only taken while waiting for the first or the next operand.
    assign in_ready  = (state_q == IDLE) || (state_q == WAIT_B);
    assign out_valid = (state_q == OUT);
    assign accept    = in_valid && in_ready;

    // The adder sees the operand registers directly. In accumulate mode
    // cin_q is cleared on the first beat and never reloaded.
    assign rca_a   = op_a_q;
    assign rca_b   = op_b_q;
    assign rca_cin = cin_q;

    // Result outputs keep their values after the handshake. They change
    // only when a new transaction starts or completes an add.
    assign out_sum     = res_q;
    assign out_cout    = cout_q;
    assign out_ovf_cnt = ovf_q;

    always_comb begin
        // NOTE: every _d gets its hold value before the case statement, so no
        // path through the case can leave a signal unassigned and infer a latch.
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cin_d   = cin_q;
        mode_d  = mode_q;
        last_d  = last_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d = mode;
                    cout_d = 1'b0;
                    ovf_d  = '0;
                    if (!mode) begin
                        op_a_d  = in_data;
                        state_d = WAIT_B;
                    end else begin
                        // Accumulate starts from zero, so the first add
                        // simply loads the first beat into the running sum.
                        op_a_d  = '0;
                        op_b_d  = in_data;
                        cin_d   = 1'b0;
                        last_d  = in_last;
                        state_d = ADD;
                    end
                end
            end

            WAIT_B: begin
                // mode_q, not the live mode input, decides how B is taken.
                if (accept) begin
                    op_b_d  = in_data;
                    state_d = ADD;
                    if (!mode_q) begin
                        cin_d = in_cin;
                    end else begin
                        last_d = in_last;
                    end
                end
            end

            ADD: begin
                op_a_d = rca_sum;
                res_d  = rca_sum;
                if (!mode_q) begin
                    cout_d = rca_cout;
                end else begin
                    cout_d = cout_q | rca_cout;
                    if (rca_cout && (ovf_q != OVF_MAX)) begin
                        ovf_d = ovf_q + OVF_W'(1);
                    end
                end
                state_d = (!mode_q || last_q) ? OUT : WAIT_B;
            end

            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge value of every other flop.
    // NOTE: all state, including the operand and result registers, is reset.
    // This guarantees that an aborted transaction leaves nothing visible on
    // rca_* or out_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cin_q   <= 1'b0;
            mode_q  <= 1'b0;
            last_q  <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cin_q   <= cin_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rca_acc_seq.sv
// ---------------------------------------------------------------------------
// tb_rca_acc_seq
//
// Directed bench for rca_acc_seq. A behavioural 3-bit adder closes the
// rca_* loop. Each transaction pushes its hand-computed result into a
// scoreboard queue. A monitor pops one entry on every result handshake and
// compares it. Timing-related properties (latency, in_ready during ADD,
// backpressure and reset behaviour) are checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_rca_acc_seq;

    localparam int W     = 3;
    localparam int OVF_W = 4;

    typedef struct packed {
        logic [W-1:0]     sum;
        logic             cout;
        logic [OVF_W-1:0] ovf;
    } result_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_cin;
    logic             in_last;
    logic             mode;
    logic [W-1:0]     rca_a;
    logic [W-1:0]     rca_b;
    logic             rca_cin;
    logic [W-1:0]     rca_sum;
    logic             rca_cout;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_cout;
    logic [OVF_W-1:0] out_ovf_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    result_t sb[$];

    rca_acc_seq #(.W(W), .OVF_W(OVF_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_cin      (in_cin),
        .in_last     (in_last),
        .mode        (mode),
        .rca_a       (rca_a),
        .rca_b       (rca_b),
        .rca_cin     (rca_cin),
        .rca_sum     (rca_sum),
        .rca_cout    (rca_cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .out_ovf_cnt (out_ovf_cnt)
    );

    // Behavioural ripple-carry adder: {cout, sum} = a + b + cin.
    assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {{W{1'b0}}, rca_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor. Outputs are sampled on the falling edge. A result
    // is consumed at the next rising edge when out_valid && out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_result: got sum %0d with an empty scoreboard (t=%0t)", out_sum, $time);
            end else begin
                result_t e;
                e = sb.pop_front();
                check("sb_out_sum",  32'(out_sum),     32'(e.sum));
                check("sb_out_cout", 32'(out_cout),    32'(e.cout));
                check("sb_out_ovf",  32'(out_ovf_cnt), 32'(e.ovf));
            end
        end
    end

    // Presents one beat, waits (bounded) until it is accepted, and returns
    // #1 after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d, input logic c, input logic l, input logic m);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        in_last  = l;
        mode     = m;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("beat_accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cin    = 1'b0;
        in_last   = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_out_sum",   32'(out_sum),     32'd0);
        check("rst_out_cout",  32'(out_cout),    32'd0);
        check("rst_out_ovf",   32'(out_ovf_cnt), 32'd0);
        check("rst_rca_a",     32'(rca_a),       32'd0);
        check("rst_rca_b",     32'(rca_b),       32'd0);
        check("rst_rca_cin",   32'(rca_cin),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pair 3 + 2, cin 0 -> 5, cout 0. B is accepted, then one ADD cycle,
        // then OUT.
        sb.push_back('{sum: 3'd5, cout: 1'b0, ovf: 4'd0});
        send_beat(3'd3, 1'b0, 1'b0, 1'b0);
        send_beat(3'd2, 1'b0, 1'b0, 1'b0);
        check("p1_add_rca_a",     32'(rca_a),     32'd3);
        check("p1_add_rca_b",     32'(rca_b),     32'd2);
        check("p1_add_in_ready",  32'(in_ready),  32'd0);
        check("p1_add_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("p1_latency_out_valid", 32'(out_valid), 32'd1);

        // Pair 7 + 7, cin 1 -> 15 = 7 mod 8 with cout 1. in_last on A and
        // mode=1 on B must both be ignored.
        sb.push_back('{sum: 3'd7, cout: 1'b1, ovf: 4'd0});
        send_beat(3'd7, 1'b0, 1'b1, 1'b0);
        send_beat(3'd7, 1'b1, 1'b0, 1'b1);
        check("p2_add_rca_cin", 32'(rca_cin), 32'd1);
        @(posedge clk);
        #1;
        check("p2_latency_out_valid", 32'(out_valid), 32'd1);

        // Accumulate 3,4,5 -> 12 = 4 mod 8, one carry (on 7+5).
        sb.push_back('{sum: 3'd4, cout: 1'b1, ovf: 4'd1});
        send_beat(3'd3, 1'b0, 1'b0, 1'b1);
        check("a1_add1_in_ready", 32'(in_ready), 32'd0);
        send_beat(3'd4, 1'b0, 1'b0, 1'b1);
        check("a1_add2_in_ready", 32'(in_ready), 32'd0);
        send_beat(3'd5, 1'b0, 1'b1, 1'b1);
        check("a1_add3_in_ready", 32'(in_ready), 32'd0);
        check("a1_add3_rca_a",    32'(rca_a),    32'd7);
        @(posedge clk);
        #1;
        check("a1_latency_out_valid", 32'(out_valid), 32'd1);

        // Accumulate twenty 7s: 140 = 4 mod 8. More than 15 adds carry, so
        // the counter saturates. The mode input toggles on later beats and
        // must be ignored.
        sb.push_back('{sum: 3'd4, cout: 1'b1, ovf: 4'd15});
        for (int i = 0; i < 20; i++) begin
            send_beat(3'd7, 1'b0, (i == 19), (i == 0) ? 1'b1 : 1'(i % 2));
        end
        @(posedge clk);
        #1;
        check("a2_latency_out_valid", 32'(out_valid), 32'd1);

        // Accumulate with in_last on the first beat: result is 0 + 6.
        sb.push_back('{sum: 3'd6, cout: 1'b0, ovf: 4'd0});
        send_beat(3'd6, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("a3_latency_out_valid", 32'(out_valid), 32'd1);

        // Backpressure: pair 1 + 1 held in OUT for five clocks while in_valid
        // is high. The result must stay stable and no beat may be taken.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        sb.push_back('{sum: 3'd2, cout: 1'b0, ovf: 4'd0});
        send_beat(3'd1, 1'b0, 1'b0, 1'b0);
        send_beat(3'd1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 3'd5;
        mode     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sum",   32'(out_sum),   32'd2);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_in_ready",  32'(in_ready),  32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        check("bp_idle_out_sum",   32'(out_sum),   32'd2);

        // Reset during the ADD cycle of an accumulate stream. No result may
        // ever be emitted for the aborted stream.
        send_beat(3'd3, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_in_ready",  32'(in_ready),  32'd1);
        check("mr_rca_a",     32'(rca_a),     32'd0);
        check("mr_rca_b",     32'(rca_b),     32'd0);
        check("mr_out_sum",   32'(out_sum),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pair 2 + 2 after reset -> 4.
        sb.push_back('{sum: 3'd4, cout: 1'b0, ovf: 4'd0});
        send_beat(3'd2, 1'b0, 1'b0, 1'b0);
        send_beat(3'd2, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pr_latency_out_valid", 32'(out_valid), 32'd1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
